// File: rtl/ysyx_22050133_ifu.sv
// Instruction fetch unit: owns the architectural PC, issues one single-beat AXI4 read at a time,
// and holds each fetched instruction at the IF/ID boundary until decode accepts it.
module ysyx_22050133_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect_valid,
    input  logic [63:0] i_redirect_pc,
    input  logic        i_stall,
    output logic        o_arvalid,
    output logic [31:0] o_araddr,
    output logic [2:0]  o_arsize,
    input  logic        i_arready,
    input  logic        i_rvalid,
    input  logic [63:0] i_rdata,
    input  logic [1:0]  i_rresp,
    output logic        o_rready,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [63:0] o_pc_out,
    output logic        o_fetch_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

    state_e      r_state;
    logic [63:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_drop;
    logic [31:0] r_inst;
    logic [63:0] r_pc_out;
    logic        r_inst_valid;
    logic        r_fetch_err;

    logic [63:0] w_target;
    logic [63:0] w_pc_inc;
    logic [31:0] w_rsel;

    assign w_target = i_redirect_pc & ~64'h3;
    assign w_pc_inc = r_pc + 64'd4;
    // Bus is 64 bits wide; PC bit 2 picks the 32-bit half holding the instruction.
    assign w_rsel   = r_pc[2] ? i_rdata[63:32] : i_rdata[31:0];

    assign o_arvalid    = (r_state == StReq);
    assign o_rready     = (r_state == StWait);
    assign o_araddr     = r_req_addr;
    assign o_arsize     = 3'b010;
    assign o_inst_valid = r_inst_valid;
    assign o_inst       = r_inst;
    assign o_pc_out     = r_pc_out;
    assign o_fetch_err  = r_fetch_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC[31:0];
            r_drop       <= 1'b0;
            r_inst       <= 32'h0;
            r_pc_out     <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_state <= StReq;
                    if (i_redirect_valid) begin
                        r_pc       <= w_target;
                        r_req_addr <= w_target[31:0];
                    end else begin
                        r_req_addr <= r_pc[31:0];
                    end
                end
                StReq: begin
                    // Address stays put until handshake; a redirect only poisons the reply.
                    if (i_redirect_valid) begin
                        r_pc   <= w_target;
                        r_drop <= 1'b1;
                    end
                    if (i_arready) begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (i_rvalid) begin
                        if (r_drop || i_redirect_valid) begin
                            r_drop  <= 1'b0;
                            r_state <= StReq;
                            if (i_redirect_valid) begin
                                r_pc       <= w_target;
                                r_req_addr <= w_target[31:0];
                            end else begin
                                r_req_addr <= r_pc[31:0];
                            end
                        end else begin
                            r_inst_valid <= 1'b1;
                            r_pc_out     <= r_pc;
                            r_state      <= StOut;
                            if (i_rresp != 2'b00) begin
                                r_inst      <= 32'h0000_0013;
                                r_fetch_err <= 1'b1;
                            end else begin
                                r_inst      <= w_rsel;
                                r_fetch_err <= 1'b0;
                            end
                        end
                    end else if (i_redirect_valid) begin
                        r_pc   <= w_target;
                        r_drop <= 1'b1;
                    end
                end
                StOut: begin
                    // Redirect outranks stall: the held instruction is on the wrong path.
                    if (i_redirect_valid) begin
                        r_pc         <= w_target;
                        r_req_addr   <= w_target[31:0];
                        r_inst_valid <= 1'b0;
                        r_fetch_err  <= 1'b0;
                        r_state      <= StReq;
                    end else if (!i_stall) begin
                        r_pc         <= w_pc_inc;
                        r_req_addr   <= w_pc_inc[31:0];
                        r_inst_valid <= 1'b0;
                        r_fetch_err  <= 1'b0;
                        r_state      <= StReq;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// Randomized scoreboard bench for ysyx_22050133_ifu: a behavioural AXI memory serves reads and a
// PC-sequence model predicts every instruction presented to decode.
module tb_ysyx_22050133_ifu;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_redirect_valid;
    logic [63:0] i_redirect_pc;
    logic        i_stall;
    logic        o_arvalid;
    logic [31:0] o_araddr;
    logic [2:0]  o_arsize;
    logic        i_arready;
    logic        i_rvalid;
    logic [63:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        o_rready;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [63:0] o_pc_out;
    logic        o_fetch_err;

    always #5 clk = ~clk;

    ysyx_22050133_ifu #(.RESET_PC(RESET_PC)) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .i_stall          (i_stall),
        .o_arvalid        (o_arvalid),
        .o_araddr         (o_araddr),
        .o_arsize         (o_arsize),
        .i_arready        (i_arready),
        .i_rvalid         (i_rvalid),
        .i_rdata          (i_rdata),
        .i_rresp          (i_rresp),
        .o_rready         (o_rready),
        .o_inst_valid     (o_inst_valid),
        .o_inst           (o_inst),
        .o_pc_out         (o_pc_out),
        .o_fetch_err      (o_fetch_err)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_pres = 0;
    logic zero_mode;

    // Driver / memory-model state
    logic [63:0] m_pc;
    logic        pend;
    logic [31:0] paddr;
    int          dly;
    logic        ar_hs;
    logic [31:0] ar_addr;
    logic        r_hs;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        if (a == 32'h8000_0004) return 32'h0000_0297;
        return (a ^ 32'hA5A5_5A5A) * 32'h9E37_79B1;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return (a == 32'h8000_0008) || (w[7:0] < 8'h08);
    endfunction

    function automatic exp_t make_exp(input logic [63:0] pc);
        exp_t e;
        e.pc   = pc;
        e.err  = mem_err(pc[31:0]);
        e.inst = e.err ? 32'h0000_0013 : mem_word(pc[31:0]);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Choose control inputs for the next edge and advance the PC-sequence model.
    task automatic pick_ctrl();
        logic [63:0] tgt;
        if (zero_mode) begin
            i_stall          = 1'b0;
            i_arready        = 1'b1;
            i_redirect_valid = 1'b0;
        end else begin
            i_stall          = ($urandom % 3) == 0;
            i_arready        = ($urandom % 4) != 0;
            i_redirect_valid = ($urandom % 10) == 0;
        end
        case ($urandom % 5)
            0: tgt = 64'h0000_0000_8000_0100;
            1: tgt = 64'hFFFF_FFFF_FFFF_FFFC;
            2: tgt = 64'h0000_0000_8000_0008;
            3: tgt = {32'h0, 32'h8000_0000 | ($urandom & 32'hFFF)};
            default: tgt = {$urandom, $urandom};
        endcase
        i_redirect_pc = tgt;
        if (i_redirect_valid) begin
            m_pc = tgt & ~64'h3;
            exp_q.delete();
            exp_q.push_back(make_exp(m_pc));
        end else if (o_inst_valid && !i_stall) begin
            m_pc = m_pc + 64'd4;
            exp_q.push_back(make_exp(m_pc));
        end
    endtask

    task automatic step();
        logic [31:0] base;
        if (r_hs) pend = 1'b0;
        if (ar_hs) begin
            pend  = 1'b1;
            paddr = ar_addr;
            dly   = zero_mode ? 0 : int'($urandom % 4);
        end
        if (!pend) begin
            i_rvalid = 1'b0;
            i_rdata  = {$urandom, $urandom};
            i_rresp  = 2'($urandom);
        end else if (!i_rvalid) begin
            if (dly == 0) begin
                base     = paddr & ~32'h7;
                i_rvalid = 1'b1;
                i_rdata  = {mem_word(base | 32'h4), mem_word(base)};
                i_rresp  = mem_err(paddr) ? 2'b10 : 2'b00;
            end else begin
                dly--;
            end
        end
        pick_ctrl();
        ar_hs   = o_arvalid && i_arready;
        ar_addr = o_araddr;
        r_hs    = o_rready && i_rvalid;
    endtask

    task automatic do_reset();
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_arvalid", o_arvalid, 0);
        chk("rst_rready", o_rready, 0);
        chk("rst_inst_valid", o_inst_valid, 0);
        chk("rst_inst", o_inst, 0);
        chk("rst_pc_out", o_pc_out, RESET_PC);
        chk("rst_fetch_err", o_fetch_err, 0);
        exp_q.delete();
        m_pc = RESET_PC;
        exp_q.push_back(make_exp(m_pc));
        pend = 1'b0;
        @(negedge clk);
        #1;
        i_rst = 1'b0;
        // Stale beat from the abandoned read arrives while the unit sits in IDLE.
        i_rvalid = 1'b1;
        i_rdata  = {$urandom, $urandom};
        i_rresp  = 2'b00;
        pick_ctrl();
        ar_hs   = o_arvalid && i_arready;
        ar_addr = o_araddr;
        r_hs    = o_rready && i_rvalid;
    endtask

    // Monitor
    logic        prev_valid;
    logic        prev_arvalid;
    logic [31:0] prev_araddr;
    int          gap;
    logic        clean;
    logic        have_cur;
    exp_t        cur;

    always @(negedge clk) begin
        if (i_rst) begin
            prev_valid   = 1'b0;
            prev_arvalid = 1'b0;
            gap          = 0;
            clean        = 1'b1;
            have_cur     = 1'b0;
        end else begin
            gap++;
            if (!zero_mode) clean = 1'b0;
            if (prev_valid) chk("valid_hold_or_release", o_inst_valid,
                                i_stall && !i_redirect_valid);
            if (prev_arvalid && !i_arready) begin
                chk("arvalid_held", o_arvalid, 1);
                chk("araddr_stable", o_araddr, prev_araddr);
            end
            chk("ar_r_exclusive", o_arvalid && o_rready, 0);
            if (o_inst_valid && !prev_valid) begin
                chk("queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                end
                if (clean) chk("zero_wait_latency", gap, 3);
                n_pres++;
                gap   = 0;
                clean = 1'b1;
            end
            if (o_inst_valid && have_cur) begin
                chk("pc_out", o_pc_out, cur.pc);
                chk("inst", o_inst, cur.inst);
                chk("fetch_err", o_fetch_err, cur.err);
                chk("no_ar_in_out", o_arvalid || o_rready, 0);
            end
            if (o_arvalid) chk("arsize", o_arsize, 3'b010);
            if (gap > 300) begin
                chk("liveness_gap", gap, 0);
                gap = 0;
            end
            prev_valid   = o_inst_valid;
            prev_arvalid = o_arvalid;
            prev_araddr  = o_araddr;
        end
    end

    initial begin
        i_rst            = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 64'h0;
        i_stall          = 1'b0;
        i_arready        = 1'b0;
        i_rvalid         = 1'b0;
        i_rdata          = 64'h0;
        i_rresp          = 2'b00;
        zero_mode        = 1'b1;
        pend             = 1'b0;
        dly              = 0;
        paddr            = 32'h0;
        ar_hs            = 1'b0;
        ar_addr          = 32'h0;
        r_hs             = 1'b0;
        m_pc             = RESET_PC;
        exp_q.push_back(make_exp(m_pc));
        repeat (2) @(negedge clk);
        #1;
        chk("init_pc_out", o_pc_out, RESET_PC);
        chk("init_inst_valid", o_inst_valid, 0);
        i_rst = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            #1;
            if (cyc == 40) zero_mode = 1'b0;
            if (!zero_mode && ($urandom % 300) == 0) do_reset();
            else step();
        end
        @(negedge clk);
        chk("presentations_seen", n_pres > 100, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
